// File: rtl/gray_counter_pkg.sv
// rtl/gray_counter_pkg.sv - shared constants and Gray/binary helpers for gray_counter_n
package gray_counter_pkg;

  localparam int WIDTH_MAX = 16;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] gray);
    logic [WIDTH_MAX-1:0] bin;
    bin[WIDTH_MAX-1] = gray[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// rtl/gray2bin_n.sv - combinational WIDTH-bit Gray to binary decoder (prefix XOR from the MSB)
module gray2bin_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  assign bin_out[WIDTH-1] = gray_in[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_prefix
    assign bin_out[i] = ^gray_in[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - N-bit up/down Gray counter with load, sticky flags and wrap pulse
// Define GRAY_COUNTER_N_SATURATE_EN to saturate at the ends instead of wrapping.
module gray_counter_n
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
  localparam logic [WIDTH-1:0] BIN_MAX   = '1;
  localparam logic [WIDTH-1:0] BIN_MIN   = '0;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;

  gray2bin_n #(.WIDTH(WIDTH)) u_load_dec (
    .gray_in (LoadVal),
    .bin_out (load_bin)
  );

  // Flags clear first so that a wrap in the same cycle as FlagClr still sets its flag.
  always_comb begin
    bin_d  = bin_q;
    ovf_d  = ovf_q & ~FlagClr;
    udf_d  = udf_q & ~FlagClr;
    wrap_d = 1'b0;
    if (Load) begin
      bin_d = load_bin;
    end else if (En) begin
      if (Up == DIR_UP) begin
        if (bin_q == BIN_MAX) begin
          ovf_d = 1'b1;
`ifndef GRAY_COUNTER_N_SATURATE_EN
          bin_d  = BIN_MIN;
          wrap_d = 1'b1;
`endif
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == BIN_MIN) begin
          udf_d = 1'b1;
`ifndef GRAY_COUNTER_N_SATURATE_EN
          bin_d  = BIN_MAX;
          wrap_d = 1'b1;
`endif
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    // Gray is encoded from the next state so Output and Binary agree every cycle.
    gray_d = WIDTH'(bin2gray(WIDTH_MAX'(bin_d)));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      wrap_q <= wrap_d;
    end
  end

  assign Output    = gray_q;
  assign Binary    = bin_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;
  assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - randomized and directed self-checking bench for gray_counter_n at widths 3, 4 and 5
module tb_gray_counter_n;

  localparam int NI = 3;
  localparam int WD[NI] = '{3, 4, 5};
  localparam int IV[NI] = '{0, 0, 5};

  logic        clk;
  logic        rst, en, up, load, flag_clr;
  logic [15:0] load_val;

  logic [2:0] g3, b3;
  logic [3:0] g4, b4;
  logic [4:0] g5, b5;
  logic       ov3, un3, wr3, ov4, un4, wr4, ov5, un5, wr5;

  int total = 0;
  int bad = 0;

  int m_bin[NI];
  bit m_ov[NI], m_un[NI], m_wr[NI];
  logic [31:0] prev_g[NI];

  gray_counter_n #(.WIDTH(3), .INIT(0)) u_w3 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(load_val[2:0]),
    .FlagClr(flag_clr), .Output(g3), .Binary(b3), .Overflow(ov3), .Underflow(un3), .Wrap(wr3));
  gray_counter_n #(.WIDTH(4), .INIT(0)) u_w4 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(load_val[3:0]),
    .FlagClr(flag_clr), .Output(g4), .Binary(b4), .Overflow(ov4), .Underflow(un4), .Wrap(wr4));
  gray_counter_n #(.WIDTH(5), .INIT(5)) u_w5 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(load_val[4:0]),
    .FlagClr(flag_clr), .Output(g5), .Binary(b5), .Overflow(ov5), .Underflow(un5), .Wrap(wr5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < 16; s++) b ^= (g >> s);
    return b;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      int mask;
      mask = (1 << WD[k]) - 1;
      m_wr[k] = 1'b0;
      if (rst) begin
        m_bin[k] = IV[k];
        m_ov[k] = 1'b0;
        m_un[k] = 1'b0;
      end else begin
        if (flag_clr) begin
          m_ov[k] = 1'b0;
          m_un[k] = 1'b0;
        end
        if (load) begin
          m_bin[k] = g2b(int'(load_val) & mask);
        end else if (en && up) begin
          if (m_bin[k] == mask) begin
            m_ov[k] = 1'b1;
`ifndef GRAY_COUNTER_N_SATURATE_EN
            m_wr[k] = 1'b1;
            m_bin[k] = 0;
`endif
          end else m_bin[k] = m_bin[k] + 1;
        end else if (en) begin
          if (m_bin[k] == 0) begin
            m_un[k] = 1'b1;
`ifndef GRAY_COUNTER_N_SATURATE_EN
            m_wr[k] = 1'b1;
            m_bin[k] = mask;
`endif
          end else m_bin[k] = m_bin[k] - 1;
        end
      end
    end
  endtask

  task automatic check_all(input bit check_step);
    for (int k = 0; k < NI; k++) begin
      logic [31:0] og, ob;
      logic oo, ou, ow;
      case (k)
        0: begin og = 32'(g3); ob = 32'(b3); oo = ov3; ou = un3; ow = wr3; end
        1: begin og = 32'(g4); ob = 32'(b4); oo = ov4; ou = un4; ow = wr4; end
        default: begin og = 32'(g5); ob = 32'(b5); oo = ov5; ou = un5; ow = wr5; end
      endcase
      check($sformatf("w%0d_binary", WD[k]), ob, 32'(m_bin[k]));
      check($sformatf("w%0d_gray", WD[k]), og, 32'(m_bin[k] ^ (m_bin[k] >> 1)));
      check($sformatf("w%0d_overflow", WD[k]), 32'(oo), 32'(m_ov[k]));
      check($sformatf("w%0d_underflow", WD[k]), 32'(ou), 32'(m_un[k]));
      check($sformatf("w%0d_wrap", WD[k]), 32'(ow), 32'(m_wr[k]));
      if (check_step)
        check($sformatf("w%0d_one_bit_step", WD[k]), 32'(popcount(og ^ prev_g[k]) <= 1), 32'd1);
      prev_g[k] = og;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input logic [15:0] lv, input bit fc);
    rst = r; en = e; up = u; load = l; load_val = lv; flag_clr = fc;
    @(posedge clk);
    model_update();
    #1;
    check_all(!r && !l);
  endtask

  localparam logic [2:0] UP_SEQ[8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; flag_clr = 1'b0;
    for (int k = 0; k < NI; k++) prev_g[k] = '0;

    // Reset state and the 3-bit up sequence.
    step(1, 0, 0, 0, 16'h0, 0);
    check("w3_reset_gray", 32'(g3), 32'd0);
    check("w5_reset_binary", 32'(b5), 32'd5);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 16'h0, 0);
`ifndef GRAY_COUNTER_N_SATURATE_EN
      check($sformatf("w3_up_seq%0d", i), 32'(g3), 32'(UP_SEQ[i]));
      check($sformatf("w3_up_wrap%0d", i), 32'(wr3), 32'(i == 7));
`else
      check($sformatf("w3_up_sat%0d", i), 32'(g3), 32'(i < 7 ? UP_SEQ[i] : 3'b100));
      check($sformatf("w3_up_sat_wrap%0d", i), 32'(wr3), 32'd0);
`endif
    end
    check("w3_overflow_after_top", 32'(ov3), 32'd1);

    // Down from reset.
    step(1, 0, 0, 0, 16'h0, 0);
    step(0, 1, 0, 0, 16'h0, 0);
    check("w3_down_underflow", 32'(un3), 32'd1);
`ifndef GRAY_COUNTER_N_SATURATE_EN
    check("w3_down_gray", 32'(g3), 32'b100);
    check("w3_down_binary", 32'(b3), 32'd7);
    check("w3_down_wrap", 32'(wr3), 32'd1);
    step(0, 1, 0, 0, 16'h0, 0);
    check("w3_down_next_gray", 32'(g3), 32'b101);
`else
    check("w3_down_sat_binary", 32'(b3), 32'd0);
    check("w3_down_sat_wrap", 32'(wr3), 32'd0);
    step(0, 1, 0, 0, 16'h0, 0);
`endif
    check("w3_down_wrap_one_cycle", 32'(wr3), 32'd0);

    // Load has priority over En.
    step(0, 1, 1, 1, 16'b01101, 0);
    check("w4_load_binary", 32'(b4), 32'd9);
    check("w4_load_gray", 32'(g4), 32'b1101);
    step(0, 1, 1, 0, 16'h0, 0);
    check("w4_after_load_binary", 32'(b4), 32'd10);
    check("w4_after_load_gray", 32'(g4), 32'b1111);

    // Flag clear alone, then coincident with an up event at the top.
    step(1, 0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 1, 16'b0100, 0);
    step(0, 1, 1, 0, 16'h0, 0);
    check("w3_ovf_set", 32'(ov3), 32'd1);
    step(0, 0, 0, 0, 16'h0, 1);
    check("w3_ovf_cleared", 32'(ov3), 32'd0);
    step(0, 0, 0, 1, 16'b0100, 0);
    step(0, 1, 1, 0, 16'h0, 1);
    check("w3_ovf_set_wins", 32'(ov3), 32'd1);

    // Reset mid-count overrides En, Load and FlagClr.
    step(1, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 16'h0, 0);
    check("w3_count_five", 32'(b3), 32'd5);
    step(1, 1, 1, 1, 16'h7, 1);
    check("w3_reset_mid_binary", 32'(b3), 32'd0);
    check("w5_reset_mid_binary", 32'(b5), 32'd5);

    // Random traffic checked against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      bit r, l, fc;
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 15) == 0);
      fc = !l && ($urandom_range(0, 15) == 0);
      step(r, 1'($urandom), 1'($urandom), l, 16'($urandom), fc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
